// File: rtl/pipe_skid32_pkg.sv
// Shared definitions for the two-entry elastic pipeline register:
// payload width and the {sv,mv} occupancy encoding.
package pipe_pkg;

    // Payload width; the storage is built from 32-bit enable-flop banks.
    localparam int WIDTH = 32;

    // Occupancy encoding {sv,mv}. 2'b10 is illegal and decodes as EMPTY.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        TWO   = 2'b11
    } state_e;

endpackage

// File: rtl/pipe_skid32_if.sv
// Upstream/downstream valid-ready bus for pipe_skid32.
//
// Handshake: a word moves on a side only in a cycle where valid and ready
// are both high at the rising edge (in_fire / out_fire). A sender that
// raises valid holds valid and data stable until that fire happens. ready
// may be asserted without valid and carries no obligation on its own.
interface pipe_skid32_if;
    import pipe_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    // Producer-side view: drives upstream payload, consumes downstream words.
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    // The pipeline register itself.
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/pipe_skid32_ctl.sv
// Control FSM for the main/skid pair. The occupancy bits mv/sv are the
// state register, so the state is visible directly on the mv/sv outputs.
// in_ready is ~sv, a pure flop output with no path from out_ready.
module skid_ctl
    import pipe_pkg::*;
(
    input  logic clk,
    input  logic r,
    input  logic flush,
    input  logic in_valid,
    input  logic out_ready,
    output logic mv,
    output logic sv,
    output logic ld_main,
    output logic main_sel,   // 0 = in_data, 1 = skid
    output logic ld_skid
);

    logic   mv_q, mv_d;
    logic   sv_q, sv_d;
    logic   in_fire;
    logic   out_fire;
    state_e state_d;

    // Next occupancy and data-register load enables.
    always_comb begin
        in_fire  = in_valid & ~sv_q;
        out_fire = mv_q & out_ready;
        state_d  = EMPTY;
        ld_main  = 1'b0;
        main_sel = 1'b0;
        ld_skid  = 1'b0;

        case ({sv_q, mv_q})
            ONE: begin
                if (in_fire && out_fire) begin
                    ld_main = 1'b1;
                    state_d = ONE;
                end else if (out_fire) begin
                    state_d = EMPTY;
                end else if (in_fire) begin
                    ld_skid = 1'b1;
                    state_d = TWO;
                end else begin
                    state_d = ONE;
                end
            end
            TWO: begin
                // in_ready is low here, so only the drain can happen.
                if (out_fire) begin
                    ld_main  = 1'b1;
                    main_sel = 1'b1;
                    state_d  = ONE;
                end else begin
                    state_d = TWO;
                end
            end
            default: begin
                // EMPTY, and the illegal 2'b10 which recovers as EMPTY.
                if (in_fire) begin
                    ld_main = 1'b1;
                    state_d = ONE;
                end
            end
        endcase

        // Flush squashes everything and must not disturb the data banks.
        if (flush) begin
            state_d  = EMPTY;
            ld_main  = 1'b0;
            main_sel = 1'b0;
            ld_skid  = 1'b0;
        end

        mv_d = state_d[0];
        sv_d = state_d[1];
    end

    // Occupancy flops, cleared asynchronously by r.
    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            mv_q <= 1'b0;
            sv_q <= 1'b0;
        end else begin
            mv_q <= mv_d;
            sv_q <= sv_d;
        end
    end

    assign mv = mv_q;
    assign sv = sv_q;

endmodule

// File: rtl/pipe_skid32.sv
// Two-entry elastic pipeline register (main + skid) for a 32-bit payload.
// out_data always shows the main entry; the skid entry catches the word
// accepted in the cycle the consumer stalls.
module pipe_skid32 #(
    parameter int WIDTH = 32   // only 32 is supported by the flop banks
) (
    input  logic               clk,
    input  logic               r,
    input  logic               flush,
    pipe_skid32_if.slave       bus
);

    logic             mv;
    logic             sv;
    logic             ld_main;
    logic             main_sel;
    logic             ld_skid;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;

    skid_ctl u_ctl (
        .clk       (clk),
        .r         (r),
        .flush     (flush),
        .in_valid  (bus.in_valid),
        .out_ready (bus.out_ready),
        .mv        (mv),
        .sv        (sv),
        .ld_main   (ld_main),
        .main_sel  (main_sel),
        .ld_skid   (ld_skid)
    );

    // Enable-flop bank inputs: main takes in_data or the skid word.
    always_comb begin
        main_d = main_q;
        skid_d = skid_q;
        if (ld_main) begin
            main_d = main_sel ? skid_q : bus.in_data;
        end
        if (ld_skid) begin
            skid_d = bus.in_data;
        end
    end

    // Main and skid payload banks; only reset ever clears them.
    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            main_q <= main_d;
            skid_q <= skid_d;
        end
    end

    assign bus.out_valid = mv;
    assign bus.in_ready  = ~sv;
    assign bus.out_data  = main_q;

endmodule

// File: tb/tb_pipe_skid32.sv
// Bench for pipe_skid32: a reference queue of held words (capacity 2)
// predicts out_valid, in_ready and out_data every cycle.
module tb_pipe_skid32;

    logic clk;
    logic r;
    logic flush;
    int   checks;
    int   errors;

    logic [31:0] exp_q[$];

    pipe_skid32_if bus ();

    pipe_skid32 #(.WIDTH(32)) dut (
        .clk   (clk),
        .r     (r),
        .flush (flush),
        .bus   (bus)
    );

    // Clock: 10 time-unit period, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, check outputs against the model
    // before the edge, then advance the model with the same inputs.
    task automatic drive_cycle(input logic iv, input logic [31:0] id,
                               input logic ordy, input logic fl,
                               output logic acc);
        bus.in_valid  = iv;
        bus.in_data   = id;
        bus.out_ready = ordy;
        flush         = fl;
        @(negedge clk);
        chk("out_valid", 32'(bus.out_valid), 32'(exp_q.size() > 0));
        chk("in_ready", 32'(bus.in_ready), 32'(exp_q.size() < 2));
        if (exp_q.size() > 0) chk("out_data", bus.out_data, exp_q[0]);
        acc = iv && (exp_q.size() < 2);
        if (ordy && exp_q.size() > 0) void'(exp_q.pop_front());
        if (fl) exp_q.delete();
        else if (acc) exp_q.push_back(id);
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input logic iv, input logic [31:0] id, input logic ordy, input logic fl);
        logic acc;
        drive_cycle(iv, id, ordy, fl, acc);
    endtask

    task automatic drain();
        for (int i = 0; i < 4; i++) cyc(1'b0, 32'h0, 1'b1, 1'b0);
    endtask

    // Main sequence.
    initial begin
        logic        pend;
        logic [31:0] pdata;
        logic        acc;
        logic        ordy;
        logic        fl;

        checks = 0;
        errors = 0;
        r = 1'b0;
        flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.out_ready = 1'b0;

        // Reset held with inputs toggling.
        for (int i = 0; i < 4; i++) begin
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.in_data   = $urandom;
            bus.out_ready = 1'($urandom_range(0, 1));
            flush         = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
            chk("rst_in_ready", 32'(bus.in_ready), 32'h1);
            chk("rst_out_data", bus.out_data, 32'h0);
            @(posedge clk);
            #1;
        end
        r = 1'b1;

        // Streaming.
        cyc(1'b1, 32'h1, 1'b1, 1'b0);
        cyc(1'b1, 32'h2, 1'b1, 1'b0);
        cyc(1'b1, 32'h3, 1'b1, 1'b0);
        drain();

        // Skid fill, 0xC held upstream until room appears.
        cyc(1'b1, 32'hA, 1'b0, 1'b0);
        cyc(1'b1, 32'hB, 1'b0, 1'b0);
        cyc(1'b1, 32'hC, 1'b0, 1'b0);
        cyc(1'b1, 32'hC, 1'b0, 1'b0);
        drive_cycle(1'b1, 32'hC, 1'b1, 1'b0, acc);
        chk("skid_c_blocked", 32'(acc), 32'h0);
        drive_cycle(1'b1, 32'hC, 1'b1, 1'b0, acc);
        chk("skid_c_taken", 32'(acc), 32'h1);
        drain();

        // Simultaneous fire in ONE.
        cyc(1'b1, 32'h5, 1'b0, 1'b0);
        cyc(1'b1, 32'h6, 1'b1, 1'b0);
        cyc(1'b0, 32'h0, 1'b0, 1'b0);
        chk("sim_out_data", bus.out_data, 32'h6);
        drain();

        // Flush from TWO with fires on both sides.
        cyc(1'b1, 32'h7, 1'b0, 1'b0);
        cyc(1'b1, 32'h8, 1'b0, 1'b0);
        cyc(1'b1, 32'h9, 1'b1, 1'b1);
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        cyc(1'b0, 32'h0, 1'b1, 1'b0);

        // Asynchronous reset with two words held.
        cyc(1'b1, 32'h11, 1'b0, 1'b0);
        cyc(1'b1, 32'h22, 1'b0, 1'b0);
        bus.in_valid = 1'b0;
        #2;
        r = 1'b0;
        #1;
        chk("arst_out_valid", 32'(bus.out_valid), 32'h0);
        chk("arst_in_ready", 32'(bus.in_ready), 32'h1);
        chk("arst_out_data", bus.out_data, 32'h0);
        exp_q.delete();
        @(posedge clk);
        #3;
        r = 1'b1;
        cyc(1'b0, 32'h0, 1'b1, 1'b0);

        // Random traffic against the reference queue.
        pend = 1'b0;
        pdata = '0;
        for (int i = 0; i < 10000; i++) begin
            if (!pend && $urandom_range(0, 3) != 0) begin
                pend  = 1'b1;
                pdata = $urandom;
            end
            ordy = ($urandom_range(0, 2) != 0);
            fl   = ($urandom_range(0, 63) == 0);
            drive_cycle(pend, pdata, ordy, fl, acc);
            if (acc) pend = 1'b0;
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_skid32.md
# pipe_skid32

Two-entry elastic pipeline register (main + skid) carrying a 32-bit payload between adjacent pipeline stages with a valid/ready handshake. It sits directly downstream of the enable-flop register banks: its storage is built from 32-bit enable-flop banks, and it supplies the enable, stall and flush control those banks need. The skid entry absorbs the one in-flight word produced when the consumer stalls, so `in_ready` is a pure flop output and no combinational path runs from `out_ready` to `in_ready`.

## Interface
- `WIDTH`, 32, payload width in bits. The datapath uses 32-bit enable-flop banks, so only 32 is supported.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `r`  in  1  reset, asynchronous, active-low. It forces all state to the reset values below immediately, independent of `clk`.
- `flush`  in  1  synchronous squash; discards all held entries at the next edge.
- `in_valid`  in  1  upstream presents `in_data`.
- `in_ready`  out  1  block can accept a word this cycle.
- `in_data`  in  WIDTH  upstream payload.
- `out_valid`  out  1  `out_data` holds a valid word.
- `out_ready`  in  1  downstream accepts `out_data` this cycle.
- `out_data`  out  WIDTH  payload of the main entry.

## Operation
- Handshake definitions:
  - `in_fire = in_valid & in_ready`.
  - `out_fire = out_valid & out_ready`.
  - A word transfers only on a fire; otherwise the sender holds valid and data stable.
- State bits:
  - `mv` marks the main entry valid; `sv` marks the skid entry valid.
  - Encoding `{sv,mv}`: EMPTY = 00, ONE = 01, TWO = 11.
  - 10 is illegal; it decodes as EMPTY and leaves next cycle as EMPTY (or ONE if `in_fire`).
- Outputs: `out_valid = mv`, `in_ready = ~sv`, `out_data = main`.
- Transitions (no flush):
  - EMPTY, `in_fire`: main <= in_data, go to ONE.
  - ONE, `in_fire & out_fire`: main <= in_data, stay in ONE.
  - ONE, `out_fire` only: go to EMPTY.
  - ONE, `in_fire` only: skid <= in_data, go to TWO.
  - ONE, idle: hold.
  - TWO, `out_fire`: main <= skid, go to ONE. `in_fire` is impossible here because `in_ready = 0`.
  - TWO, idle: hold.
- Flush:
  - When `flush = 1`, the next state is EMPTY regardless of `in_fire` or `out_fire`.
  - Data registers are not written on flush.
  - An `out_fire` in the flush cycle still counts as a delivered word; an `in_fire` in that cycle is dropped.
- Data registers load only under the enables listed above and otherwise hold. They are never cleared except by reset.
- Ordering is strictly FIFO: the skid word never overtakes the main word.

## Timing
- Reset values, asserted while `r = 0`:
  - `mv = 0`, `sv = 0`.
  - `out_valid = 0`, `in_ready = 1`.
  - main = 0, skid = 0, so `out_data = 32'h0`.
- Release of `r` is synchronised externally; the first edge after release operates normally.
- Reset asserted mid-transfer: all held words are lost and `out_valid` drops immediately (asynchronous).
- Latency: 1 cycle, from `in_fire` at edge N to `out_valid = 1` with that data after edge N.
- Throughput: 1 word per cycle while `out_ready = 1`.
- Stall response: `in_ready` falls one cycle after the first stalled `in_fire` (on entry to TWO). It rises one cycle after the `out_fire` that leaves TWO.
- Capacity: at most 2 words held. With `out_ready` held at 0, exactly two words are accepted before `in_ready = 0`.

## Structure
- Shared package `pipe_pkg` holds:
  - the state encoding constants EMPTY, ONE, TWO (2-bit);
  - `WIDTH` default 32.
- Sub-module `skid_ctl` contains the control FSM:
  - Inputs: `clk`, `r`, `flush`, `in_valid`, `out_ready`.
  - Outputs: `mv`, `sv`, `ld_main`, `main_sel` (0 = in_data, 1 = skid), `ld_skid`.
  - `mv` and `sv` are held in enable flops tied to `clk`/`r`.
- Top level datapath:
  - main and skid registers are 32-bit enable-flop banks;
  - a 2:1 mux on the main input, selected by `main_sel`;
  - no other logic.

## Test plan
- **Reset:** hold `r = 0` with random inputs toggling. Required: `out_valid = 0`, `in_ready = 1`, `out_data = 0`. Assert `r = 0` mid-run with two words held. Required: `out_valid` drops with no clock edge.
- **Streaming:** `out_ready = 1`, send 0x1, 0x2, 0x3 back-to-back. Required: each appears on `out_data` one cycle after its fire, `in_ready` stays 1, no gaps.
- **Skid fill:** `out_ready = 0`, send 0xA, 0xB, 0xC.
  - Required: 0xA and 0xB are accepted; `in_ready = 0` after 0xB; 0xC is held upstream.
  - Then raise `out_ready`. Required: order 0xA, 0xB, 0xC with `in_ready` returning to 1 one cycle after 0xA drains.
- **Simultaneous fire in ONE:** main = 0x5, `in_valid` with 0x6 and `out_ready = 1`. Required: 0x5 delivered, state ONE, `out_data = 0x6` next cycle.
- **Flush:** state TWO (0x7, 0x8), pulse `flush` with `out_ready = 1` and `in_valid = 1` carrying 0x9. Required: 0x7 counted delivered, next cycle `out_valid = 0` and `in_ready = 1`, and 0x8 and 0x9 are never output.
- **Random traffic:** random `in_valid`, `out_ready` and `flush` for 10k cycles against a reference queue model. Required: no loss, duplication or reordering except the flush drops defined above.
